// File: rtl/mii_tx_framer.sv
// mii_tx_framer: drains a PHY-TX FIFO (byte + end-of-frame delimiter) onto a
// 100 Mb/s MII transmit port. Adds preamble/SFD, enforces the inter-frame gap,
// and aborts frames on FIFO underrun or when they exceed MAX_BYTES.
module mii_tx_framer #(
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_BYTES   = 1522
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic        frame_ready,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_del,
  output logic        fifo_rden,
  output logic [3:0]  mii_txd,
  output logic        mii_txen,
  output logic        mii_txer,
  output logic [15:0] frames_sent,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_DRAIN,
    S_IFG
  } state_t;

  localparam logic [4:0]  PRE_LAST = 5'd14;
  localparam logic [4:0]  IFG_LAST = 5'(IFG_NIBBLES - 1);
  localparam logic [10:0] MAX_N    = 11'(MAX_BYTES);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;     // preamble / IFG cycle counter
  logic        ph_q, ph_d;       // DATA nibble phase: 0 = low, 1 = high
  logic [7:0]  b_q, b_d;         // byte currently on the wire
  logic        d_q, d_d;         // delimiter of that byte
  logic [10:0] n_q, n_d;         // bytes sent in the current frame
  logic        rd_q;             // a FIFO pop was issued last cycle
  logic [15:0] fs_q, fs_d;
  logic [7:0]  ec_q, ec_d;

  logic        start_ok;
  logic        good_evt;
  logic        err_evt;
  logic [10:0] n_inc;

  assign start_ok = tx_enable && frame_ready && !fifo_empty;
  assign n_inc    = n_q + 11'd1;

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ph_q    <= 1'b0;
      b_q     <= '0;
      d_q     <= 1'b0;
      n_q     <= '0;
      rd_q    <= 1'b0;
      fs_q    <= '0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      b_q     <= b_d;
      d_q     <= d_d;
      n_q     <= n_d;
      rd_q    <= fifo_rden;
      fs_q    <= fs_d;
      ec_q    <= ec_d;
    end
  end

  // Next-state and datapath updates.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    b_d      = b_q;
    d_d      = d_q;
    n_d      = n_q;
    good_evt = 1'b0;
    err_evt  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_PREAMBLE;
          cnt_d   = '0;
          n_d     = '0;
        end
      end

      S_PREAMBLE: begin
        cnt_d = cnt_q + 5'd1;
        // The prefetch pop happens in preamble cycle 0; its data is valid
        // in cycle 1 and stays put until the next pop.
        if (cnt_q == 5'd1) begin
          b_d = fifo_dout;
          d_d = fifo_del;
        end
        if (cnt_q == PRE_LAST) state_d = S_SFD;
      end

      S_SFD: begin
        state_d = S_DATA;
        ph_d    = 1'b0;
      end

      S_DATA: begin
        if (!ph_q) begin
          if (!d_q && fifo_empty) begin
            err_evt = 1'b1;
            state_d = S_DRAIN;
          end else begin
            ph_d = 1'b1;
          end
        end else begin
          n_d  = n_inc;
          ph_d = 1'b0;
          if (d_q) begin
            good_evt = 1'b1;
            state_d  = S_IFG;
            cnt_d    = '0;
          end else if (n_inc == MAX_N) begin
            err_evt = 1'b1;
            // The byte popped in phase 0 is visible now; if it already ends
            // the frame there is nothing left to drain.
            if (fifo_del) begin
              state_d = S_IFG;
              cnt_d   = '0;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            b_d = fifo_dout;
            d_d = fifo_del;
          end
        end
      end

      S_DRAIN: begin
        if (rd_q && fifo_del) begin
          state_d = S_IFG;
          cnt_d   = '0;
        end
      end

      S_IFG: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == IFG_LAST) begin
          // Starting straight from the last gap cycle keeps back-to-back
          // frames exactly IFG_NIBBLES apart.
          if (start_ok) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
            n_d     = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    fs_d = fs_q + {15'd0, good_evt};
    ec_d = (err_evt && (ec_q != 8'hFF)) ? ec_q + 8'd1 : ec_q;
  end

  // MII and FIFO outputs decoded from the current state.
  always_comb begin
    fifo_rden = 1'b0;
    mii_txd   = 4'h0;
    mii_txen  = 1'b0;
    mii_txer  = 1'b0;

    unique case (state_q)
      S_PREAMBLE: begin
        mii_txen  = 1'b1;
        mii_txd   = 4'h5;
        fifo_rden = (cnt_q == 5'd0) && !fifo_empty;
      end
      S_SFD: begin
        mii_txen = 1'b1;
        mii_txd  = 4'hD;
      end
      S_DATA: begin
        mii_txen = 1'b1;
        mii_txd  = ph_q ? b_q[7:4] : b_q[3:0];
        if (!ph_q) begin
          if (!d_q) begin
            if (fifo_empty) mii_txer  = 1'b1;
            else            fifo_rden = 1'b1;
          end
        end else begin
          mii_txer = !d_q && (n_inc == MAX_N);
        end
      end
      S_DRAIN: begin
        // At most one pop every other cycle so each delimiter is seen
        // before the next pop is considered.
        fifo_rden = !rd_q && !fifo_empty;
      end
      default: ;
    endcase
  end

  assign frames_sent = fs_q;
  assign err_count   = ec_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mii_tx_framer.sv
// Bench for mii_tx_framer: FIFO model, nibble scoreboard, timing checks.
module tb_mii_tx_framer;
  localparam int MAXB = 1522;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_enable = 1'b0;
  logic        frame_ready = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_del = 1'b0;
  logic        fifo_rden;
  logic [3:0]  mii_txd;
  logic        mii_txen;
  logic        mii_txer;
  logic [15:0] frames_sent;
  logic [7:0]  err_count;
  logic        busy;

  mii_tx_framer #(.IFG_NIBBLES(24), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .frame_ready(frame_ready),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_del(fifo_del),
    .fifo_rden(fifo_rden), .mii_txd(mii_txd), .mii_txen(mii_txen),
    .mii_txer(mii_txer), .frames_sent(frames_sent), .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [8:0] fq[$];    // FIFO model: {del, data}
  logic [4:0] exq[$];   // expected {txer, txd} while txen is high
  int  dels = 0;
  bit  fr_force = 1'b0;
  int  pops = 0;
  int  cyc = 0;
  bit  txen_p = 1'b0;
  bit  rise_seen = 1'b0;
  int  rise_cyc = 0, fall_cyc = 0, last_len = 0, last_gap = 0;
  int  exp_frames = 0, exp_err = 0;
  int  p0, c0, n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic upd_flags();
    fifo_empty  = (fq.size() == 0);
    frame_ready = (dels > 0) || fr_force;
  endtask

  task automatic push_bytes(input int len, input int base, input bit del_last);
    for (int k = 0; k < len; k++) begin
      logic d;
      d = del_last && (k == len - 1);
      fq.push_back({d, 8'(base + k)});
      if (d) dels++;
    end
    upd_flags();
  endtask

  // kind 0: good frame, 1: underrun on the phase-0 cycle of the last byte,
  // 2: oversize abort on the high nibble of byte MAXB-1.
  task automatic exp_frame(input int len, input int base, input int kind);
    logic [7:0] v;
    int nfull;
    repeat (15) exq.push_back(5'h05);
    exq.push_back(5'h0D);
    nfull = (kind == 0) ? len : (kind == 1) ? len - 1 : MAXB - 1;
    for (int k = 0; k < nfull; k++) begin
      v = 8'(base + k);
      exq.push_back({1'b0, v[3:0]});
      exq.push_back({1'b0, v[7:4]});
    end
    v = 8'(base + nfull);
    if (kind == 1) begin
      exq.push_back({1'b1, v[3:0]});
    end else if (kind == 2) begin
      exq.push_back({1'b0, v[3:0]});
      exq.push_back({1'b1, v[7:4]});
    end
  endtask

  // One clock: sample outputs mid-cycle, then let the FIFO model act on the edge.
  task automatic step();
    bit rd;
    #1;
    if (!rst) begin
      if (mii_txen) begin
        if (exq.size() == 0) begin
          check("txen_unexpected", 32'(mii_txen), 32'(0));
        end else begin
          logic [4:0] x;
          x = exq.pop_front();
          check("nibble", 32'({mii_txer, mii_txd}), 32'(x));
        end
      end else if (mii_txer) begin
        check("txer_idle", 32'(mii_txer), 32'(0));
      end
      if (mii_txen && !txen_p) begin
        last_gap  = cyc - fall_cyc;
        rise_cyc  = cyc;
        rise_seen = 1'b1;
      end
      if (!mii_txen && txen_p) begin
        fall_cyc = cyc;
        last_len = cyc - rise_cyc;
      end
      txen_p = mii_txen;
    end
    rd = fifo_rden;
    @(posedge clk);
    #1;
    cyc++;
    if (rd) begin
      if (fq.size() == 0) begin
        check("pop_empty", 32'(fifo_empty), 32'(0));
      end else begin
        logic [8:0] e;
        e = fq.pop_front();
        fifo_dout = e[7:0];
        fifo_del  = e[8];
        pops++;
        if (e[8]) dels--;
      end
    end
    upd_flags();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    do begin step(); k++; end while (!busy && k < 5);
    while (busy && k < budget) begin step(); k++; end
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    check({tag, "_txen"}, 32'(mii_txen), 32'(0));
    check({tag, "_txer"}, 32'(mii_txer), 32'(0));
    check({tag, "_txd"}, 32'(mii_txd), 32'(0));
    check({tag, "_rden"}, 32'(fifo_rden), 32'(0));
    check({tag, "_frames"}, 32'(frames_sent), 32'(0));
    check({tag, "_err"}, 32'(err_count), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    exq.delete();
    fq.delete();
    dels = 0;
    fr_force = 1'b0;
    upd_flags();
    step();
    rst = 1'b0;
    exp_frames = 0;
    exp_err = 0;
    txen_p = 1'b0;
    rise_seen = 1'b0;
  endtask

  initial begin
    do_reset("rst0");
    tx_enable = 1'b1;

    // 64-byte frame 0x00..0x3F
    p0 = pops;
    exp_frame(64, 0, 0);
    push_bytes(64, 0, 1'b1);
    wait_idle(400, "t1_idle");
    exp_frames++;
    check("t1_txen_len", 32'(last_len), 32'(144));
    check("t1_pops", 32'(pops - p0), 32'(64));
    check("t1_frames", 32'(frames_sent), 32'(exp_frames));
    check("t1_sb_left", 32'(exq.size()), 32'(0));

    // Two frames back to back
    p0 = pops;
    exp_frame(64, 8'h40, 0);
    exp_frame(64, 8'h80, 0);
    push_bytes(64, 8'h40, 1'b1);
    push_bytes(64, 8'h80, 1'b1);
    wait_idle(800, "t2_idle");
    exp_frames += 2;
    check("t2_gap", 32'(last_gap), 32'(24));
    check("t2_txen_len", 32'(last_len), 32'(144));
    check("t2_pops", 32'(pops - p0), 32'(128));
    check("t2_frames", 32'(frames_sent), 32'(exp_frames));

    // tx_enable low holds a ready frame back
    tx_enable = 1'b0;
    p0 = pops;
    push_bytes(8, 8'hA0, 1'b1);
    repeat (30) step();
    check("t3_no_pops", 32'(pops - p0), 32'(0));
    check("t3_busy", 32'(busy), 32'(0));
    check("t3_txen", 32'(mii_txen), 32'(0));
    exp_frame(8, 8'hA0, 0);
    c0 = cyc;
    tx_enable = 1'b1;
    step();
    check("t3_txen_rise", 32'(mii_txen), 32'(1));
    check("t3_rden", 32'(fifo_rden), 32'(1));
    wait_idle(200, "t3_idle");
    exp_frames++;
    check("t3_rise_cyc", 32'(rise_cyc), 32'(c0 + 1));
    check("t3_txen_len", 32'(last_len), 32'(32));
    check("t3_frames", 32'(frames_sent), 32'(exp_frames));

    // Underrun: ten bytes, no delimiter, then the FIFO runs dry
    p0 = pops;
    exp_frame(10, 8'h30, 1);
    fr_force = 1'b1;
    push_bytes(10, 8'h30, 1'b0);
    step();
    step();
    fr_force = 1'b0;
    upd_flags();
    repeat (60) step();
    exp_err++;
    check("t4_err", 32'(err_count), 32'(exp_err));
    check("t4_txen_len", 32'(last_len), 32'(35));
    check("t4_draining", 32'(busy), 32'(1));
    check("t4_pops", 32'(pops - p0), 32'(10));
    check("t4_sb_left", 32'(exq.size()), 32'(0));
    push_bytes(5, 8'h50, 1'b1);
    wait_idle(200, "t4_idle");
    check("t4_drain_pops", 32'(pops - p0), 32'(15));
    check("t4_fifo_left", 32'(fq.size()), 32'(0));
    check("t4_frames", 32'(frames_sent), 32'(exp_frames));
    check("t4_err2", 32'(err_count), 32'(exp_err));

    // Oversize: 1530-byte frame
    do_reset("rst1");
    p0 = pops;
    exp_frame(1530, 0, 2);
    push_bytes(1530, 0, 1'b1);
    wait_idle(4000, "t5_idle");
    exp_err++;
    check("t5_err", 32'(err_count), 32'(exp_err));
    check("t5_frames", 32'(frames_sent), 32'(exp_frames));
    check("t5_pops", 32'(pops - p0), 32'(1530));
    check("t5_fifo_left", 32'(fq.size()), 32'(0));
    check("t5_txen_len", 32'(last_len), 32'(16 + 2 * MAXB));
    check("t5_sb_left", 32'(exq.size()), 32'(0));

    // Reset in the middle of byte 20
    exp_frame(64, 8'h10, 0);
    push_bytes(64, 8'h10, 1'b1);
    rise_seen = 1'b0;
    n = 0;
    while (!rise_seen && n < 50) begin step(); n++; end
    check("t6_started", 32'(rise_seen), 32'(1));
    n = 0;
    while (cyc < rise_cyc + 56 && n < 200) begin step(); n++; end
    #1;
    check("t6_byte20_lo", 32'(mii_txd), 32'(4));
    do_reset("t6_rst");

    // Recovery after reset
    exp_frame(4, 8'h70, 0);
    push_bytes(4, 8'h70, 1'b1);
    wait_idle(200, "t7_idle");
    exp_frames++;
    check("t7_frames", 32'(frames_sent), 32'(exp_frames));
    check("t7_txen_len", 32'(last_len), 32'(24));
    check("t7_sb_left", 32'(exq.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
